// File: rtl/matrix_pkg.sv
// Types and constants shared by the 8x8 RGB matrix driver and its wishbone frame loader.
package matrix_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_ACK,
      RD_REQ,
      RD_ACK,
      DONE
   } state_t;

   localparam int ROW_COUNT = 8;

   // Each pixel is a 0bxRGB nibble; column 0 sits in the top nibble of a row word.
   localparam int RED   = 2;
   localparam int GREEN = 1;
   localparam int BLUE  = 0;

endpackage

// File: rtl/matrix_wb_loader.sv
// Wishbone master that writes a captured 8-row colour frame into the matrix driver and
// optionally reads every row back to confirm it landed.
module matrix_wb_loader #(
   parameter int WB_DATA_WIDTH = 32,
   parameter int ROW_COUNT     = matrix_pkg::ROW_COUNT,
   parameter int WB_ADDR_WIDTH = $clog2(ROW_COUNT),
   parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
   parameter int ACK_TIMEOUT   = 64
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               i_frame_valid,
   input  logic [ROW_COUNT*WB_DATA_WIDTH-1:0] i_frame_data,
   input  logic                               i_verify,
   output logic                               o_frame_ready,
   output logic                               o_busy,
   output logic                               o_done,
   output logic                               o_error,
   output logic [WB_ADDR_WIDTH-1:0]           o_mismatch_row,
   output logic                               o_wb_cyc,
   output logic                               o_wb_stb,
   output logic                               o_wb_we,
   output logic [WB_ADDR_WIDTH-1:0]           o_wb_addr,
   output logic [WB_SEL_WIDTH-1:0]            o_wb_sel,
   output logic [WB_DATA_WIDTH-1:0]           o_wb_wdata,
   input  logic                               i_wb_ack,
   input  logic                               i_wb_stall,
   input  logic [WB_DATA_WIDTH-1:0]           i_wb_rdata
);
   import matrix_pkg::*;

   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

   state_t                   state, state_nx;
   logic [WB_ADDR_WIDTH-1:0] row, row_nx;
   logic [TMO_W-1:0]         tmo;
   logic [WB_DATA_WIDTH-1:0] frame_buf [ROW_COUNT];
   logic                     verify_q;
   logic                     error_q;
   logic [WB_ADDR_WIDTH-1:0] mismatch_q;

   logic accept, stb_acc, tmo_inc, set_err, set_mm;
   logic last_row, tmo_hit;

   assign last_row = (row == WB_ADDR_WIDTH'(ROW_COUNT - 1));
   assign tmo_hit  = (tmo == TMO_W'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      row_nx        = row;
      o_frame_ready = 1'b0;
      o_wb_cyc      = 1'b0;
      o_wb_stb      = 1'b0;
      o_wb_we       = 1'b0;
      o_done        = 1'b0;
      accept        = 1'b0;
      stb_acc       = 1'b0;
      tmo_inc       = 1'b0;
      set_err       = 1'b0;
      set_mm        = 1'b0;
      unique case (state)
         IDLE: begin
            o_frame_ready = 1'b1;
            if (i_frame_valid) begin
               accept   = 1'b1;
               row_nx   = '0;
               state_nx = WR_REQ;
            end
         end
         WR_REQ, RD_REQ: begin
            o_wb_cyc = 1'b1;
            o_wb_stb = 1'b1;
            o_wb_we  = (state == WR_REQ);
            if (!i_wb_stall) begin
               stb_acc  = 1'b1;
               state_nx = (state == WR_REQ) ? WR_ACK : RD_ACK;
            end
         end
         WR_ACK: begin
            o_wb_cyc = 1'b1;
            o_wb_we  = 1'b1;
            // Ack takes priority over a timeout landing on the same cycle.
            if (i_wb_ack) begin
               if (last_row) begin
                  row_nx   = '0;
                  state_nx = verify_q ? RD_REQ : DONE;
               end else begin
                  row_nx   = row + 1'b1;
                  state_nx = WR_REQ;
               end
            end else if (tmo_hit) begin
               set_err  = 1'b1;
               state_nx = IDLE;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         RD_ACK: begin
            o_wb_cyc = 1'b1;
            if (i_wb_ack) begin
               if (i_wb_rdata != frame_buf[row]) begin
                  set_err  = 1'b1;
                  set_mm   = 1'b1;
                  state_nx = IDLE;
               end else if (last_row) begin
                  state_nx = DONE;
               end else begin
                  row_nx   = row + 1'b1;
                  state_nx = RD_REQ;
               end
            end else if (tmo_hit) begin
               set_err  = 1'b1;
               state_nx = IDLE;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         DONE: begin
            o_done   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         row        <= '0;
         tmo        <= '0;
         verify_q   <= 1'b0;
         error_q    <= 1'b0;
         mismatch_q <= '0;
         for (int r = 0; r < ROW_COUNT; r++) frame_buf[r] <= '0;
      end else begin
         row <= row_nx;
         if (stb_acc)      tmo <= '0;
         else if (tmo_inc) tmo <= tmo + 1'b1;
         if (accept) begin
            verify_q   <= i_verify;
            error_q    <= 1'b0;
            mismatch_q <= '0;
            for (int r = 0; r < ROW_COUNT; r++)
               frame_buf[r] <= i_frame_data[r*WB_DATA_WIDTH +: WB_DATA_WIDTH];
         end else begin
            if (set_err) error_q    <= 1'b1;
            if (set_mm)  mismatch_q <= row;
         end
      end
   end

   // Write data is only driven while a write is on the bus; idle bus reads as zero.
   assign o_wb_wdata     = (state == WR_REQ || state == WR_ACK) ? frame_buf[row] : '0;
   assign o_wb_addr      = row;
   assign o_wb_sel       = '1;
   assign o_busy         = (state != IDLE);
   assign o_error        = error_q;
   assign o_mismatch_row = mismatch_q;

endmodule

// File: tb/tb_matrix_wb_loader.sv
// Directed bench for matrix_wb_loader with a small wishbone slave model.
module tb_matrix_wb_loader;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         frame_valid;
   logic [255:0] frame_data;
   logic         verify;
   logic         frame_ready, busy, done, error;
   logic [2:0]   mismatch_row;
   logic         wb_cyc, wb_stb, wb_we;
   logic [2:0]   wb_addr;
   logic [3:0]   wb_sel;
   logic [31:0]  wb_wdata;
   logic         wb_ack;
   logic         wb_stall;
   logic [31:0]  wb_rdata;

   int total = 0;
   int bad   = 0;

   // slave model controls
   logic        model_clr = 1'b0;
   logic        stall_en  = 1'b0;
   logic [2:0]  stall_row = 3'd2;
   logic        no_ack    = 1'b0;
   logic        stuck     = 1'b0;
   logic [1:0]  stall_cnt;
   logic [31:0] mem      [8];
   logic [31:0] log_data [16];
   logic [2:0]  log_addr [16];
   int          wr_cnt;

   logic [31:0] rows_a [8];
   logic [31:0] rows_b [8];
   logic [255:0] fa, fb;

   always #5 clk = ~clk;

   matrix_wb_loader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_frame_valid  (frame_valid),
      .i_frame_data   (frame_data),
      .i_verify       (verify),
      .o_frame_ready  (frame_ready),
      .o_busy         (busy),
      .o_done         (done),
      .o_error        (error),
      .o_mismatch_row (mismatch_row),
      .o_wb_cyc       (wb_cyc),
      .o_wb_stb       (wb_stb),
      .o_wb_we        (wb_we),
      .o_wb_addr      (wb_addr),
      .o_wb_sel       (wb_sel),
      .o_wb_wdata     (wb_wdata),
      .i_wb_ack       (wb_ack),
      .i_wb_stall     (wb_stall),
      .i_wb_rdata     (wb_rdata)
   );

   // Slave: stalls the first three offers of the chosen write row, acks one cycle after acceptance.
   assign wb_stall = stall_en && wb_stb && wb_we && (wb_addr == stall_row) && (stall_cnt != 2'd3);

   always @(posedge clk) begin
      if (!reset_n || model_clr) begin
         wb_ack    <= 1'b0;
         wb_rdata  <= '0;
         wr_cnt    <= 0;
         stall_cnt <= '0;
         if (model_clr) for (int i = 0; i < 8; i++) mem[i] <= '0;
      end else begin
         if (wb_stall) stall_cnt <= stall_cnt + 1'b1;
         wb_ack <= !no_ack && wb_cyc && wb_stb && !wb_stall;
         if (wb_cyc && wb_stb && !wb_stall) begin
            if (wb_we) begin
               mem[wb_addr] <= wb_wdata;
               if (wr_cnt < 16) begin
                  log_data[wr_cnt] <= wb_wdata;
                  log_addr[wr_cnt] <= wb_addr;
               end
               wr_cnt <= wr_cnt + 1;
            end else begin
               wb_rdata <= mem[wb_addr] | ((stuck && wb_addr == 3'd5) ? 32'h10 : 32'h0);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clr_model();
      model_clr = 1'b1;
      step(1);
      model_clr = 1'b0;
   endtask

   // Offers a frame and returns one ns after the accepting edge.
   task automatic start_frame(input logic [255:0] f, input logic v);
      frame_data  = f;
      verify      = v;
      frame_valid = 1'b1;
      step(1);
      frame_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         step(1);
         if (done) seen = 1'b1;
      end
   endtask

   initial begin
      bit seen;
      rows_a = '{32'h00666600, 32'h06000060, 32'h60600606, 32'h60000006,
                 32'h60600606, 32'h60066006, 32'h06000060, 32'h00666600};
      for (int r = 0; r < 8; r++) begin
         rows_b[r]       = 32'h77700000 | r;
         fa[r*32 +: 32]  = rows_a[r];
         fb[r*32 +: 32]  = rows_b[r];
      end
      reset_n     = 1'b0;
      frame_valid = 1'b0;
      frame_data  = '0;
      verify      = 1'b0;
      step(3);
      chk("rst_cyc", wb_cyc, 0);
      chk("rst_stb", wb_stb, 0);
      chk("rst_we", wb_we, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_addr", wb_addr, 0);
      chk("rst_wdata", wb_wdata, 0);
      chk("rst_mm", mismatch_row, 0);
      chk("rst_ready", frame_ready, 1);
      reset_n = 1'b1;
      step(1);

      // Plain write of frame A, zero-stall slave
      clr_model();
      start_frame(fa, 1'b0);
      chk("t1_busy", busy, 1);
      chk("t1_stb", wb_stb, 1);
      chk("t1_we", wb_we, 1);
      chk("t1_addr0", wb_addr, 0);
      chk("t1_wdata0", wb_wdata, rows_a[0]);
      chk("t1_sel", wb_sel, 4'hF);
      for (int k = 1; k < 16; k++) begin
         step(1);
         chk("t1_cyc_high", wb_cyc, 1);
         chk("t1_no_done", done, 0);
      end
      step(1);
      chk("t1_done", done, 1);
      chk("t1_cyc_low", wb_cyc, 0);
      step(1);
      chk("t1_done_pulse", done, 0);
      chk("t1_ready", frame_ready, 1);
      chk("t1_error", error, 0);
      chk("t1_wr_cnt", wr_cnt, 8);
      for (int r = 0; r < 8; r++) begin
         chk("t1_log_addr", log_addr[r], r);
         chk("t1_log_data", log_data[r], rows_a[r]);
      end

      // Three-cycle stall on row 2
      clr_model();
      stall_en = 1'b1;
      start_frame(fa, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (wb_stb && wb_addr == 3'd2) seen = 1'b1;
         else step(1);
      end
      chk("t2_reach_row2", seen, 1);
      for (int k = 0; k < 3; k++) begin
         step(1);
         chk("t2_stb_held", wb_stb, 1);
         chk("t2_addr_held", wb_addr, 2);
         chk("t2_wdata_held", wb_wdata, rows_a[2]);
      end
      step(1);
      chk("t2_stb_drop", wb_stb, 0);
      wait_done(40, seen);
      chk("t2_done", seen, 1);
      chk("t2_error", error, 0);
      chk("t2_wr_cnt", wr_cnt, 8);
      for (int r = 0; r < 8; r++) chk("t2_order", log_addr[r], r);
      stall_en = 1'b0;
      step(1);

      // Verify pass against a faithful slave: 16 write cycles, 16 read cycles, then DONE
      clr_model();
      start_frame(fa, 1'b1);
      step(31);
      chk("t3_cyc_reading", wb_cyc, 1);
      chk("t3_no_done_yet", done, 0);
      step(1);
      chk("t3_done", done, 1);
      chk("t3_error", error, 0);
      for (int r = 0; r < 8; r++) chk("t3_mem", mem[r], rows_a[r]);
      step(1);

      // Bit 4 of row 5 reads back stuck high
      clr_model();
      stuck = 1'b1;
      start_frame(fa, 1'b1);
      step(27);
      chk("t4_cyc_before", wb_cyc, 1);
      chk("t4_err_before", error, 0);
      step(1);
      chk("t4_error", error, 1);
      chk("t4_mm_row", mismatch_row, 5);
      chk("t4_cyc_drop", wb_cyc, 0);
      chk("t4_ready", frame_ready, 1);
      for (int k = 0; k < 3; k++) begin
         chk("t4_no_done", done, 0);
         step(1);
      end
      chk("t4_err_sticky", error, 1);
      stuck = 1'b0;

      // Slave never acks: 64 cycles in WR_ACK then abort
      clr_model();
      no_ack = 1'b1;
      start_frame(fa, 1'b0);
      step(64);
      chk("t5_cyc_wait", wb_cyc, 1);
      chk("t5_err_wait", error, 0);
      step(1);
      chk("t5_error", error, 1);
      chk("t5_cyc", wb_cyc, 0);
      chk("t5_ready", frame_ready, 1);
      no_ack = 1'b0;
      clr_model();
      start_frame(fb, 1'b0);
      chk("t5_err_clear", error, 0);
      step(16);
      chk("t5_done_after", done, 1);
      step(1);

      // Reset during the row 3 write, then a fresh frame
      clr_model();
      start_frame(fb, 1'b0);
      step(6);
      chk("t6_row3", wb_addr, 3);
      chk("t6_row3_stb", wb_stb, 1);
      reset_n = 1'b0;
      step(1);
      chk("t6_cyc", wb_cyc, 0);
      chk("t6_stb", wb_stb, 0);
      chk("t6_we", wb_we, 0);
      chk("t6_addr", wb_addr, 0);
      chk("t6_wdata", wb_wdata, 0);
      chk("t6_done", done, 0);
      chk("t6_error", error, 0);
      chk("t6_mm", mismatch_row, 0);
      reset_n = 1'b1;
      step(1);
      start_frame(fb, 1'b0);
      chk("t6_restart_addr", wb_addr, 0);
      chk("t6_restart_data", wb_wdata, rows_b[0]);
      chk("t6_restart_stb", wb_stb, 1);
      step(16);
      chk("t6_done", done, 1);
      chk("t6_wr_cnt", wr_cnt, 8);
      chk("t6_last_data", log_data[7], rows_b[7]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
